// File: rtl/ts4231_pkg.sv
// Shared state encoding, default timing constants and a width helper for the
// TS4231 configuration scheduler.
package ts4231_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_RUN,
      ST_SETTLE,
      ST_NEXT
   } state_t;

   localparam int DEF_N_SENSORS      = 4;
   localparam int DEF_TIMEOUT_CYCLES = 9600000;  // 100 ms at 96 MHz
   localparam int DEF_RETRY_LIMIT    = 3;
   localparam int DEF_SETTLE_CYCLES  = 96;
   localparam int GUARD_CYCLES       = 2;        // stale cfg_configured ignored this long

   // Counter width for a limit, never below one bit.
   function automatic int cw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ts4231_config_scheduler_rr_pick.sv
// Combinational round-robin picker: first pending index after 'last', wrapping,
// with 'last' itself as the lowest-priority candidate.
module rr_pick
   import ts4231_pkg::*;
#(
   parameter int N  = DEF_N_SENSORS,
   parameter int IW = cw(N)
) (
   input  logic [N-1:0]  pending,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] idx,
   output logic          valid
);

   int          c;
   logic [IW-1:0] ci;

   // Scan from farthest to nearest so the nearest pending index wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      c     = 0;
      ci    = '0;
      for (int k = N; k >= 1; k--) begin
         c  = (int'(last) + k) % N;
         ci = IW'(c);
         if (pending[ci]) begin
            idx   = ci;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ts4231_config_scheduler.sv
// Time-shares one TS4231 configurator across N sensors: round-robin service of
// pending sensors with per-attempt timeout, retry limit and post-service settle.
module ts4231_config_scheduler
   import ts4231_pkg::*;
#(
   parameter int N_SENSORS      = DEF_N_SENSORS,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int RETRY_LIMIT    = DEF_RETRY_LIMIT,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
   input  logic                       clk_96MHz,
   input  logic                       reset,
   input  logic [N_SENSORS-1:0]       sensor_lost,
   input  logic                       cfg_configured,
   output logic                       cfg_reconfigure,
   output logic [cw(N_SENSORS)-1:0]   sel,
   output logic [N_SENSORS-1:0]       sensor_configured,
   output logic [N_SENSORS-1:0]       sensor_failed,
   output logic                       busy
);

   localparam int IW = cw(N_SENSORS);
   localparam int TW = cw(TIMEOUT_CYCLES);
   localparam int AW = cw(RETRY_LIMIT + 1);
   localparam int SW = cw(SETTLE_CYCLES);

   state_t               state, state_nx;
   logic [N_SENSORS-1:0] pending, sel_mask, clr_mask;
   logic [IW-1:0]        last, pick;
   logic                 pick_vld;
   logic [TW-1:0]        tmr;
   logic [AW-1:0]        att;
   logic [SW-1:0]        scnt;
   logic                 gap, relost;
   logic                 in_run, success, tmo, final_tmo, done;

   rr_pick #(.N(N_SENSORS), .IW(IW)) u_pick (
      .pending (pending),
      .last    (last),
      .idx     (pick),
      .valid   (pick_vld)
   );

   // gap marks the single low cycle between retries; it is not part of an attempt.
   assign in_run    = (state == ST_RUN) && !gap;
   assign success   = in_run && (tmr >= TW'(GUARD_CYCLES)) && cfg_configured;
   assign tmo       = in_run && (tmr == TW'(TIMEOUT_CYCLES - 1)) && !success;
   assign final_tmo = tmo && ((int'(att) + 1) >= RETRY_LIMIT);
   assign done      = success || final_tmo;

   assign sel_mask  = N_SENSORS'(1) << sel;
   // A re-loss seen while serving keeps the sensor pending for another pass.
   assign clr_mask  = (done && !relost) ? sel_mask : '0;

   assign cfg_reconfigure = in_run;
   assign busy            = (state != ST_IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (|pending) state_nx = ST_SELECT;
         ST_SELECT: state_nx = pick_vld ? ST_RUN : ST_IDLE;
         ST_RUN:    if (done) state_nx = ST_SETTLE;
         ST_SETTLE: if (scnt == SW'(SETTLE_CYCLES - 1)) state_nx = ST_NEXT;
         ST_NEXT:   state_nx = (|pending) ? ST_SELECT : ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         state             <= ST_IDLE;
         pending           <= '1;
         last              <= IW'(N_SENSORS - 1);
         sel               <= '0;
         sensor_configured <= '0;
         sensor_failed     <= '0;
         tmr               <= '0;
         att               <= '0;
         scnt              <= '0;
         gap               <= 1'b0;
         relost            <= 1'b0;
      end else begin
         state             <= state_nx;
         pending           <= (pending & ~clr_mask) | sensor_lost;
         sensor_configured <= (sensor_configured | (success ? sel_mask : '0)) & ~sensor_lost;
         sensor_failed     <= (sensor_failed | (final_tmo ? sel_mask : '0)) & ~sensor_lost;
         if ((state == ST_RUN || state == ST_SETTLE) && sensor_lost[sel])
            relost <= 1'b1;
         case (state)
            ST_SELECT: begin
               if (pick_vld) sel <= pick;
               att    <= '0;
               tmr    <= '0;
               gap    <= 1'b0;
               relost <= 1'b0;
            end
            ST_RUN: begin
               scnt <= '0;
               if (gap) begin
                  gap <= 1'b0;
               end else if (tmo) begin
                  att <= att + 1'b1;
                  tmr <= '0;
                  gap <= !final_tmo;
               end else if (!success) begin
                  tmr <= tmr + 1'b1;
               end
            end
            ST_SETTLE: scnt <= scnt + 1'b1;
            ST_NEXT:   last <= sel;
            default:   ;
         endcase
      end
   end

endmodule

// File: tb/tb_ts4231_config_scheduler.sv
// Directed bench: a small configurator model answers 10 cycles into each
// reconfigure request for responsive sensors; a monitor logs service order.
module tb_ts4231_config_scheduler;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] sensor_lost = '0;
   logic         cfg_configured = 1'b0;
   logic         cfg_reconfigure;
   logic [1:0]   sel;
   logic [N-1:0] sensor_configured, sensor_failed;
   logic         busy;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] resp = '1;
   logic         force_hi = 1'b0;
   int           rcnt = 0;

   int order_q[$];
   int hi_q[$];
   int lo_q[$];
   logic prev_rc = 1'b0;
   int   hilen = 0;
   int   lolen = 0;

   ts4231_config_scheduler #(
      .N_SENSORS(4), .TIMEOUT_CYCLES(100), .RETRY_LIMIT(2), .SETTLE_CYCLES(4)
   ) dut (
      .clk_96MHz         (clk),
      .reset             (reset),
      .sensor_lost       (sensor_lost),
      .cfg_configured    (cfg_configured),
      .cfg_reconfigure   (cfg_reconfigure),
      .sel               (sel),
      .sensor_configured (sensor_configured),
      .sensor_failed     (sensor_failed),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   // Configurator model: flag rises on the 10th request cycle for responsive sensors.
   always @(negedge clk) begin
      if (reset || !cfg_reconfigure) begin
         rcnt = 0;
         cfg_configured = force_hi;
      end else begin
         rcnt++;
         cfg_configured = force_hi || (resp[sel] && rcnt >= 10);
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         prev_rc = 1'b0;
         hilen = 0;
         lolen = 0;
      end else begin
         if (cfg_reconfigure) begin
            if (!prev_rc) begin
               order_q.push_back(int'(sel));
               lo_q.push_back(lolen);
               hilen = 0;
            end
            hilen++;
         end else begin
            if (prev_rc) begin
               hi_q.push_back(hilen);
               lolen = 0;
            end
            lolen++;
         end
         prev_rc = cfg_reconfigure;
      end
   end

   task automatic wait_idle(input string name);
      bit seen = 0;
      bit ok = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (busy) seen = 1;
         else if (seen) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_idle: busy did not return low within 3000 cycles", name);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks += 5;
      if (cfg_reconfigure !== 1'b0) begin errors++; $display("FAIL reset_reconf: got %b want 0", cfg_reconfigure); end
      if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (sensor_configured !== 4'b0000) begin errors++; $display("FAIL reset_cfg: got %b want 0000", sensor_configured); end
      if (sensor_failed !== 4'b0000) begin errors++; $display("FAIL reset_failed: got %b want 0000", sensor_failed); end
   endtask

   task automatic test_all_ok();
      int exp_o[$] = '{0, 1, 2, 3};
      int bo, bh;
      resp = 4'b1111;
      do_reset();
      bo = order_q.size();
      bh = hi_q.size();
      wait_idle("all_ok");
      checks++;
      if (order_q.size() - bo != 4) begin errors++; $display("FAIL all_ok_count: got %0d attempts want 4", order_q.size() - bo); end
      else for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (order_q[bo+i] != exp_o[i]) begin errors++; $display("FAIL all_ok_order[%0d]: got %0d want %0d", i, order_q[bo+i], exp_o[i]); end
         if (hi_q[bh+i] != 10) begin errors++; $display("FAIL all_ok_hilen[%0d]: got %0d want 10", i, hi_q[bh+i]); end
      end
      checks += 3;
      if (order_q.size() - bo >= 2 && lo_q[bo+1] != 6) begin errors++; $display("FAIL all_ok_settle_gap: got %0d want 6", lo_q[bo+1]); end
      if (sensor_configured !== 4'b1111) begin errors++; $display("FAIL all_ok_cfg: got %b want 1111", sensor_configured); end
      if (sensor_failed !== 4'b0000) begin errors++; $display("FAIL all_ok_failed: got %b want 0000", sensor_failed); end
   endtask

   task automatic test_timeout();
      int exp_o[$] = '{0, 1, 1, 2, 3};
      int exp_h[$] = '{10, 100, 100, 10, 10};
      int bo, bh;
      resp = 4'b1101;
      do_reset();
      bo = order_q.size();
      bh = hi_q.size();
      wait_idle("timeout");
      checks++;
      if (order_q.size() - bo != 5) begin errors++; $display("FAIL timeout_count: got %0d attempts want 5", order_q.size() - bo); end
      else begin
         for (int i = 0; i < 5; i++) begin
            checks += 2;
            if (order_q[bo+i] != exp_o[i]) begin errors++; $display("FAIL timeout_order[%0d]: got %0d want %0d", i, order_q[bo+i], exp_o[i]); end
            if (hi_q[bh+i] != exp_h[i]) begin errors++; $display("FAIL timeout_hilen[%0d]: got %0d want %0d", i, hi_q[bh+i], exp_h[i]); end
         end
         checks++;
         if (lo_q[bo+2] != 1) begin errors++; $display("FAIL timeout_retry_gap: got %0d want 1", lo_q[bo+2]); end
      end
      checks += 2;
      if (sensor_failed !== 4'b0010) begin errors++; $display("FAIL timeout_failed: got %b want 0010", sensor_failed); end
      if (sensor_configured !== 4'b1101) begin errors++; $display("FAIL timeout_cfg: got %b want 1101", sensor_configured); end
   endtask

   // Runs straight after test_timeout without reset: last-served is 3.
   task automatic test_lost_clears();
      int bo;
      resp = 4'b1111;
      bo = order_q.size();
      @(negedge clk);
      sensor_lost = 4'b0011;
      @(negedge clk);
      sensor_lost = 4'b0000;
      checks += 2;
      if (sensor_configured !== 4'b1100) begin errors++; $display("FAIL lost_clr_cfg: got %b want 1100", sensor_configured); end
      if (sensor_failed !== 4'b0000) begin errors++; $display("FAIL lost_clr_failed: got %b want 0000", sensor_failed); end
      wait_idle("lost_clr");
      checks += 2;
      if (order_q.size() - bo != 2 || order_q[bo] != 0 || order_q[bo+1] != 1) begin
         errors++; $display("FAIL lost_clr_order: got %0d attempts, want order 0,1", order_q.size() - bo);
      end
      if (sensor_configured !== 4'b1111) begin errors++; $display("FAIL lost_clr_final: got %b want 1111", sensor_configured); end
   endtask

   task automatic test_relost_during_run();
      int exp_o[$] = '{0, 1, 2, 3, 2};
      int bo;
      bit found = 0;
      resp = 4'b1111;
      do_reset();
      bo = order_q.size();
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (sel == 2'd2 && cfg_reconfigure) begin found = 1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL relost_wait: sensor 2 RUN not seen in 500 cycles"); end
      repeat (3) @(negedge clk);
      sensor_lost = 4'b0100;
      @(negedge clk);
      sensor_lost = 4'b0000;
      wait_idle("relost");
      checks++;
      if (order_q.size() - bo != 5) begin errors++; $display("FAIL relost_count: got %0d attempts want 5", order_q.size() - bo); end
      else for (int i = 0; i < 5; i++) begin
         checks++;
         if (order_q[bo+i] != exp_o[i]) begin errors++; $display("FAIL relost_order[%0d]: got %0d want %0d", i, order_q[bo+i], exp_o[i]); end
      end
      checks++;
      if (sensor_configured !== 4'b1111) begin errors++; $display("FAIL relost_cfg: got %b want 1111", sensor_configured); end
   endtask

   task automatic test_guard();
      int bh;
      force_hi = 1'b1;
      do_reset();
      bh = hi_q.size();
      wait_idle("guard");
      force_hi = 1'b0;
      checks++;
      if (hi_q.size() - bh != 4) begin errors++; $display("FAIL guard_count: got %0d attempts want 4", hi_q.size() - bh); end
      else for (int i = 0; i < 4; i++) begin
         checks++;
         if (hi_q[bh+i] != 3) begin errors++; $display("FAIL guard_hilen[%0d]: got %0d want 3", i, hi_q[bh+i]); end
      end
      checks++;
      if (sensor_configured !== 4'b1111) begin errors++; $display("FAIL guard_cfg: got %b want 1111", sensor_configured); end
   endtask

   task automatic test_reset_mid_run();
      int exp_o[$] = '{0, 1, 1, 2, 3};
      int bo;
      bit found = 0;
      resp = 4'b1101;
      do_reset();
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (sel == 2'd1 && cfg_reconfigure) begin found = 1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL midrst_wait: sensor 1 RUN not seen in 500 cycles"); end
      repeat (49) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks += 5;
      if (cfg_reconfigure !== 1'b0) begin errors++; $display("FAIL midrst_reconf: got %b want 0", cfg_reconfigure); end
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      if (sel !== 2'd0) begin errors++; $display("FAIL midrst_sel: got %0d want 0", sel); end
      if (sensor_configured !== 4'b0000) begin errors++; $display("FAIL midrst_cfg: got %b want 0000", sensor_configured); end
      if (sensor_failed !== 4'b0000) begin errors++; $display("FAIL midrst_failed: got %b want 0000", sensor_failed); end
      @(negedge clk);
      reset = 1'b0;
      bo = order_q.size();
      wait_idle("midrst");
      checks++;
      if (order_q.size() - bo != 5) begin errors++; $display("FAIL midrst_count: got %0d attempts want 5", order_q.size() - bo); end
      else for (int i = 0; i < 5; i++) begin
         checks++;
         if (order_q[bo+i] != exp_o[i]) begin errors++; $display("FAIL midrst_order[%0d]: got %0d want %0d", i, order_q[bo+i], exp_o[i]); end
      end
      checks++;
      if (sensor_failed !== 4'b0010) begin errors++; $display("FAIL midrst_final_failed: got %b want 0010", sensor_failed); end
   endtask

   initial begin
      test_reset();
      test_all_ok();
      test_timeout();
      test_lost_clears();
      test_relost_during_run();
      test_guard();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
